pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16; PC width in bits.
REQ-002 Parameter STEP, default 2; sequential increment, power of two, less than 2^WIDTH.
REQ-003 Parameter RESET_PC, default 0; PC value after reset.
REQ-004 Parameter HIST_DEPTH, default 3, min 1; number of previous-PC history entries.
REQ-005 Port clk, input, 1; single clock, rising-edge.
REQ-006 Port rst_n, input, 1; asynchronous active-low reset.
REQ-007 Port stall_i, input, 1; hold PC this cycle.
REQ-008 Port redirect_i, input, 1; load redirect_pc_i (branch/jump).
REQ-009 Port redirect_pc_i, input, WIDTH; redirect target.
REQ-010 Port halt_i, input, 1; request halt.
REQ-011 Port resume_i, input, 1; leave HALTED.
REQ-012 Port pc_o, output, WIDTH; current PC.
REQ-013 Port pc_next_o, output, WIDTH; combinational value pc_o takes at next edge.
REQ-014 Port pc_valid_o, output, 1; pc_o is a fetchable address this cycle.
REQ-015 Port state_o, output, 2; FSM state encoding from pc_pkg.
REQ-016 Port hist_o, output, HIST_DEPTH*WIDTH; entry k at bits [k*WIDTH +: WIDTH], entry 0 newest.
REQ-017 Port misalign_o, output, 1; misaligned-redirect fault pulse.

Function
REQ-018 FSM states RUN=0, REDIR=1, HALTED=2; encoding 3 unused, SHALL recover to RUN.
REQ-019 Per-cycle priority: redirect_i > halt_i > stall_i > increment.
REQ-020 RUN, no event: pc_o <= pc_o + STEP mod 2^WIDTH (all-ones wrap to low value, no flag).
REQ-021 RUN or REDIR with redirect_i: pc_o <= redirect_pc_i; next state REDIR.
REQ-022 REDIR: pc_valid_o=0; without a new redirect, PC holds and next state RUN (one bubble cycle).
REQ-023 RUN with halt_i, no redirect: PC holds; next state HALTED.
REQ-024 stall_i in RUN or REDIR: PC and state hold; REDIR remains REDIR.
REQ-025 HALTED: pc_valid_o=0; PC holds; resume_i -> RUN next cycle; halt_i ignored.
REQ-026 HALTED with redirect_i: PC loaded; state stays HALTED, unless resume_i is also set -> RUN.
REQ-027 pc_valid_o = 1 only in RUN.
REQ-028 PC update: history shifts; entry 0 <= old pc_o; entry k <= entry k-1. No PC update: history holds.
REQ-029 pc_next_o reflects REQ-019..026 exactly, including wrap.

Reset
REQ-030 rst_n low asynchronously forces pc_o=RESET_PC, state RUN, all history entries RESET_PC, misalign_o=0.
REQ-031 Reset mid-REDIR or mid-HALTED aborts the operation; first edge after release increments from RESET_PC unless events apply.

Configuration
REQ-032 Macro PC_ALIGN_CHK_EN defined: redirect_pc_i with nonzero bits [log2(STEP)-1:0] is not loaded.
REQ-033 In that case misalign_o pulses 1 for one cycle, next state HALTED, and history holds.
REQ-034 Macro PC_ALIGN_CHK_EN undefined: misalign_o tied 0; redirect_pc_i loaded verbatim.

Structure
REQ-035 Package pc_pkg SHALL hold the state typedef/encodings and the default parameter constants.
REQ-036 History SHALL be a sub-module pc_hist_shift (WIDTH, HIST_DEPTH, shift enable, async active-low reset).

Verification
REQ-037 Reset release, WIDTH=16, STEP=2, 4 free cycles -> pc_o 0,2,4,6,8; pc_valid_o=1 throughout.
REQ-038 pc_o=0xFFFE, no event -> pc_o=0x0000; history entry 0=0xFFFE.
REQ-039 pc_o=0x0010, redirect_i with 0x0200 and stall_i in the same cycle -> next 0x0200, REDIR, valid=0; following cycle RUN; then 0x0202.
REQ-040 halt_i at pc_o=0x0020 -> HALTED, pc holds 3 cycles, valid=0; resume_i -> RUN; then 0x0022.
REQ-041 PC_ALIGN_CHK_EN defined, redirect to 0x0101 -> pc unchanged, misalign_o one-cycle pulse, HALTED.
REQ-042 rst_n asserted asynchronously mid-REDIR -> pc_o=RESET_PC immediately, before any clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - FSM state encoding and default parameters for the PC unit
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF      = 16;
  localparam int unsigned PC_STEP_DEF       = 2;
  localparam int unsigned PC_RESET_DEF      = 0;
  localparam int unsigned PC_HIST_DEPTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REDIR  = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_hist_shift.sv
// rtl/pc_hist_shift.sv - previous-PC history shift register, entry 0 newest
module pc_hist_shift
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_WIDTH_DEF,
  parameter int unsigned      HIST_DEPTH = PC_HIST_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(PC_RESET_DEF)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        shift_en,
  input  logic [WIDTH-1:0]            din,
  output logic [HIST_DEPTH*WIDTH-1:0] hist_o
);

  logic [WIDTH-1:0] hist_q [HIST_DEPTH];
  logic [WIDTH-1:0] hist_d [HIST_DEPTH];

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d[0] = din;
      for (int k = 1; k < int'(HIST_DEPTH); k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(HIST_DEPTH); k++) begin
        hist_q[k] <= RESET_VAL;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  for (genvar g = 0; g < int'(HIST_DEPTH); g++) begin : g_pack
    assign hist_o[g*WIDTH +: WIDTH] = hist_q[g];
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with redirect/halt/stall FSM and PC history
// Define PC_ALIGN_CHK_EN to reject redirect targets not aligned to STEP.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_WIDTH_DEF,
  parameter int unsigned      STEP       = PC_STEP_DEF,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_DEF),
  parameter int unsigned      HIST_DEPTH = PC_HIST_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        redirect_i,
  input  logic [WIDTH-1:0]            redirect_pc_i,
  input  logic                        halt_i,
  input  logic                        resume_i,
  output logic [WIDTH-1:0]            pc_o,
  output logic [WIDTH-1:0]            pc_next_o,
  output logic                        pc_valid_o,
  output logic [1:0]                  state_o,
  output logic [HIST_DEPTH*WIDTH-1:0] hist_o,
  output logic                        misalign_o
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             shift_en;
  logic             bad_align;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    shift_en = 1'b0;
    case (state_q)
      ST_RUN, ST_REDIR: begin
        if (redirect_i) begin
          if (bad_align) begin
            state_d = ST_HALTED;
          end else begin
            pc_d     = redirect_pc_i;
            shift_en = 1'b1;
            state_d  = ST_REDIR;
          end
        end else if (halt_i) begin
          state_d = ST_HALTED;
        end else if (!stall_i) begin
          // REDIR spends exactly one unstalled cycle as a fetch bubble
          if (state_q == ST_RUN) begin
            pc_d     = pc_q + STEP_W;
            shift_en = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        if (redirect_i && !bad_align) begin
          pc_d     = redirect_pc_i;
          shift_en = 1'b1;
        end
        if (resume_i && !(redirect_i && bad_align)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    pc_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic misalign_q, misalign_d;

  assign bad_align  = |(redirect_pc_i & ALIGN_MASK);
  assign misalign_d = redirect_i && bad_align &&
                      (state_q inside {ST_RUN, ST_REDIR, ST_HALTED});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign bad_align  = 1'b0;
  assign misalign_o = 1'b0;
`endif

  pc_hist_shift #(
    .WIDTH      (WIDTH),
    .HIST_DEPTH (HIST_DEPTH),
    .RESET_VAL  (RESET_PC)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (pc_q),
    .hist_o   (hist_o)
  );

  assign pc_o       = pc_q;
  assign pc_next_o  = pc_d;
  assign pc_valid_o = pc_valid_q;
  assign state_o    = state_q;

endmodule
